ucsbece154b_sync_fifo: RTL and testbench
========================================

UCSBECE154B_SYNC_FIFO -- requirements
Module: ucsbece154b_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter NR_ENTRIES, default 4, storage depth; any integer >=2, power of two not required.
REQ-003 SHALL have parameter FALL_THROUGH, default 1: 1 = show-ahead output; 0 = registered output loaded on pop.
REQ-004 SHALL have parameter AFULL_THRESH, default NR_ENTRIES-1, almost-full level.
REQ-005 SHALL have parameter AEMPTY_THRESH, default 1, almost-empty level.
REQ-006 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port flush_i  input  1  synchronous empty request.
REQ-009 SHALL have port push_i  input  1  write request.
REQ-010 SHALL have port data_i  input  DATA_WIDTH  write data.
REQ-011 SHALL have port pop_i  input  1  read request.
REQ-012 SHALL have port data_o  output  DATA_WIDTH  read data.
REQ-013 SHALL have port full_o  output  1  occupancy == NR_ENTRIES.
REQ-014 SHALL have port valid_o  output  1  occupancy != 0.
REQ-015 SHALL have port count_o  output  $clog2(NR_ENTRIES+1)  current occupancy.
REQ-016 SHALL have port almost_full_o  output  1  count_o >= AFULL_THRESH.
REQ-017 SHALL have port almost_empty_o  output  1  count_o <= AEMPTY_THRESH.
REQ-018 SHALL have port overflow_o  output  1  one-cycle pulse on rejected push.
REQ-019 SHALL have port underflow_o  output  1  one-cycle pulse on rejected pop.

Function
REQ-020 Push SHALL be accepted iff push_i && !full_o && !flush_i; accepted data written at tail, tail advances.
REQ-021 Pop SHALL be accepted iff pop_i && valid_o && !flush_i; head advances.
REQ-022 Head/tail SHALL wrap from NR_ENTRIES-1 to 0 for every NR_ENTRIES, incl. non-power-of-two.
REQ-023 count_o SHALL be registered: +1 push only, -1 pop only, unchanged for both or neither.
REQ-024 full_o, valid_o, almost_full_o, almost_empty_o SHALL be registered, derived from next-state count; no combinational path from push_i/pop_i.
REQ-025 Push while full SHALL be rejected even with a simultaneous accepted pop; overflow_o pulses next cycle, contents unchanged.
REQ-026 Pop while empty SHALL be rejected even with a simultaneous push; underflow_o pulses next cycle; the push is still accepted.
REQ-027 Write-to-read latency SHALL be 1 cycle: valid_o rises the cycle after the first accepted push into an empty FIFO; no same-cycle bypass.
REQ-028 FALL_THROUGH=1: data_o SHALL equal the entry at head while valid_o=1, and SHALL be 0 while valid_o=0.
REQ-029 FALL_THROUGH=0: data_o SHALL load the head entry on an accepted pop and hold it until the next accepted pop.
REQ-030 flush_i SHALL take priority over push/pop: next cycle head=tail=0, count_o=0, valid_o=0, full_o=0, almost_empty_o=1; memory contents not cleared; no overflow/underflow pulse.
REQ-031 Ordering SHALL be strict FIFO across any number of wrap-arounds.

Reset
REQ-032 rst_ni low SHALL asynchronously clear head, tail, count_o, full_o, valid_o, almost_full_o, overflow_o, underflow_o, and data_o to 0, and set almost_empty_o to 1.
REQ-033 Storage array SHALL NOT be reset.
REQ-034 First accepted push SHALL be possible on the first rising edge after rst_ni deasserts.

Structure
REQ-035 Package ucsbece154b_fifo_pkg SHALL hold pointer/count-width helper functions and a parameter-legality check (NR_ENTRIES>=2, thresholds within 0..NR_ENTRIES).
REQ-036 Sub-module ucsbece154b_fifo_ptr (modulo-N wrap counter with increment and clear) SHALL be instantiated twice, for head and tail.
REQ-037 Storage SHALL be a flop array inferred inside ucsbece154b_sync_fifo.

Verification
REQ-038 NR_ENTRIES=3: push 0xA,0xB,0xC -> full_o=1, count_o=3; push 0xD -> overflow_o pulse; pops return 0xA,0xB,0xC; valid_o=0 after the third pop.
REQ-039 NR_ENTRIES=3: 10 push/pop pairs of 0..9 through a one-entry-deep FIFO -> pointer wrap, outputs 0..9 in order, count_o stays 1.
REQ-040 Full FIFO with push_i=pop_i=1 -> pop accepted, push rejected with overflow_o, count_o 4->3 (NR_ENTRIES=4).
REQ-041 Empty FIFO with push_i=pop_i=1, data_i=0x55 -> underflow_o pulse; next cycle valid_o=1, data_o=0x55 (FALL_THROUGH=1).
REQ-042 Two entries, flush_i=1 with push_i=1 -> next cycle count_o=0, valid_o=0, no overflow/underflow pulse; rst_ni pulsed low mid-burst -> all outputs at reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/ucsbece154b_fifo_pkg.sv
// ----------------------------------------------------------------------------
// ucsbece154b_fifo_pkg
// Shared helpers for the synchronous FIFO:
//   ptr_width()    - bits needed to index NR_ENTRIES storage slots
//   count_width()  - bits needed to hold an occupancy of 0..NR_ENTRIES
//   params_legal() - elaboration-time sanity check of depth and thresholds
// ----------------------------------------------------------------------------
package ucsbece154b_fifo_pkg;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic bit params_legal(input int n, input int afull, input int aempty);
        return (n >= 2) && (afull >= 0) && (afull <= n) && (aempty >= 0) && (aempty <= n);
    endfunction

endpackage

// File: rtl/ucsbece154b_fifo_ptr.sv
// ----------------------------------------------------------------------------
// ucsbece154b_fifo_ptr
// Modulo-NR_ENTRIES wrap counter used for the FIFO head and tail pointers.
// Wraps NR_ENTRIES-1 -> 0, so depth need not be a power of two.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (pointer -> 0)
//   clr_i  : synchronous clear, wins over inc_i
//   inc_i  : advance pointer by one slot
//   ptr_o  : current pointer value
// ----------------------------------------------------------------------------
module ucsbece154b_fifo_ptr
    import ucsbece154b_fifo_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 4,
    localparam int unsigned PW        = ptr_width(NR_ENTRIES)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    localparam logic [PW-1:0] LAST = PW'(NR_ENTRIES - 1);

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_o <= '0;
        end else if (clr_i) begin
            ptr_o <= '0;
        end else if (inc_i) begin
            ptr_o <= (ptr_o == LAST) ? '0 : ptr_o + PW'(1);
        end
    end

endmodule

// File: rtl/ucsbece154b_sync_fifo.sv
// ----------------------------------------------------------------------------
// ucsbece154b_sync_fifo
// Single-clock FIFO with registered status flags, overflow/underflow pulses,
// synchronous flush and a choice of show-ahead or registered read data.
//   clk_i          : clock
//   rst_ni         : asynchronous active-low reset
//   flush_i        : synchronous empty request, beats push/pop
//   push_i/data_i  : write request and data
//   pop_i          : read request
//   data_o         : read data (show-ahead head or last popped entry)
//   full_o         : occupancy == NR_ENTRIES
//   valid_o        : occupancy != 0
//   count_o        : occupancy
//   almost_full_o  : count_o >= AFULL_THRESH
//   almost_empty_o : count_o <= AEMPTY_THRESH
//   overflow_o     : one-cycle pulse after a rejected push
//   underflow_o    : one-cycle pulse after a rejected pop
// ----------------------------------------------------------------------------
module ucsbece154b_sync_fifo
    import ucsbece154b_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NR_ENTRIES    = 4,
    parameter bit          FALL_THROUGH  = 1'b1,
    parameter int          AFULL_THRESH  = NR_ENTRIES - 1,
    parameter int          AEMPTY_THRESH = 1,
    localparam int unsigned CW           = count_width(NR_ENTRIES)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  valid_o,
    output logic [CW-1:0]         count_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int unsigned   PW        = ptr_width(NR_ENTRIES);
    localparam logic [CW-1:0] CNT_FULL  = CW'(NR_ENTRIES);
    localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] CNT_AEMPT = CW'(AEMPTY_THRESH);

    if (!params_legal(NR_ENTRIES, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
        $error("ucsbece154b_sync_fifo: illegal NR_ENTRIES or threshold parameters");
    end

    logic [DATA_WIDTH-1:0] mem [NR_ENTRIES];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic                  push_ok;
    logic                  pop_ok;
    logic [CW-1:0]         count_d;

    // Acceptance is judged on registered flags only, so there is no
    // combinational path from push_i/pop_i to any status output.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        push_ok = push_i && !full_o  && !flush_i;
        pop_ok  = pop_i  && valid_o  && !flush_i;
        count_d = count_o;
        if (flush_i) begin
            count_d = '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_o + CW'(1);
                2'b01:   count_d = count_o - CW'(1);
                default: count_d = count_o;
            endcase
        end
    end

    // Flags are loaded from the next-state count so they line up with count_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o        <= '0;
            full_o         <= 1'b0;
            valid_o        <= 1'b0;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            count_o        <= count_d;
            full_o         <= (count_d == CNT_FULL);
            valid_o        <= (count_d != '0);
            almost_full_o  <= (count_d >= CNT_AFULL);
            almost_empty_o <= (count_d <= CNT_AEMPT);
            overflow_o     <= push_i && full_o   && !flush_i;
            underflow_o    <= pop_i  && !valid_o && !flush_i;
        end
    end

    // NOTE: storage is deliberately left out of reset; valid_o/count_o already
    // mark which slots hold live data, and a resettable array costs a mux per bit.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[tail] <= data_i;
        end
    end

    ucsbece154b_fifo_ptr #(.NR_ENTRIES(NR_ENTRIES)) u_head (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (pop_ok),
        .ptr_o  (head)
    );

    ucsbece154b_fifo_ptr #(.NR_ENTRIES(NR_ENTRIES)) u_tail (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (push_ok),
        .ptr_o  (tail)
    );

    if (FALL_THROUGH) begin : g_show_ahead
        // Head entry is visible while valid; forced to zero when empty so
        // stale storage never leaks out.
        assign data_o = valid_o ? mem[head] : '0;
    end else begin : g_registered
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_o <= '0;
            end else if (pop_ok) begin
                data_o <= mem[head];
            end
        end
    end

endmodule

// File: tb/tb_ucsbece154b_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_ucsbece154b_sync_fifo
// Drives the same stimulus into two FIFOs: a 3-deep show-ahead instance and a
// 4-deep registered-output instance, and compares every output each cycle
// against a queue-based model of the FIFO rules.
// ----------------------------------------------------------------------------
module tb_ucsbece154b_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       push;
    logic       pop;
    logic [7:0] din;

    logic [7:0] dout_a, dout_b;
    logic       full_a, full_b, valid_a, valid_b;
    logic [1:0] cnt_a;
    logic [2:0] cnt_b;
    logic       af_a, af_b, ae_a, ae_b, ovf_a, ovf_b, unf_a, unf_b;

    int total = 0;
    int bad   = 0;

    // Reference model: contents as queues, plus expected pulses and the
    // registered-output value of instance b.
    logic [7:0] mq0 [$];
    logic [7:0] mq1 [$];
    logic [7:0] exp_dout_b;
    logic [1:0] exp_ovf;
    logic [1:0] exp_unf;

    ucsbece154b_sync_fifo #(
        .DATA_WIDTH   (8),
        .NR_ENTRIES   (3),
        .FALL_THROUGH (1'b1)
    ) u_dut_a (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .push_i         (push),
        .data_i         (din),
        .pop_i          (pop),
        .data_o         (dout_a),
        .full_o         (full_a),
        .valid_o        (valid_a),
        .count_o        (cnt_a),
        .almost_full_o  (af_a),
        .almost_empty_o (ae_a),
        .overflow_o     (ovf_a),
        .underflow_o    (unf_a)
    );

    ucsbece154b_sync_fifo #(
        .DATA_WIDTH   (8),
        .NR_ENTRIES   (4),
        .FALL_THROUGH (1'b0)
    ) u_dut_b (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .push_i         (push),
        .data_i         (din),
        .pop_i          (pop),
        .data_o         (dout_b),
        .full_o         (full_b),
        .valid_o        (valid_b),
        .count_o        (cnt_b),
        .almost_full_o  (af_b),
        .almost_empty_o (ae_b),
        .overflow_o     (ovf_b),
        .underflow_o    (unf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input int k);
        int         sz;
        int         cap;
        int         af_t;
        logic [7:0] ed;
        string      p;
        if (k == 0) begin
            sz   = mq0.size();
            cap  = 3;
            af_t = 2;
            ed   = (sz != 0) ? mq0[0] : 8'h00;
            p    = "a";
        end else begin
            sz   = mq1.size();
            cap  = 4;
            af_t = 3;
            ed   = exp_dout_b;
            p    = "b";
        end
        check({p, ".count"},  k ? 32'(cnt_b)   : 32'(cnt_a),   32'(sz));
        check({p, ".full"},   k ? 32'(full_b)  : 32'(full_a),  32'(sz == cap));
        check({p, ".valid"},  k ? 32'(valid_b) : 32'(valid_a), 32'(sz != 0));
        check({p, ".afull"},  k ? 32'(af_b)    : 32'(af_a),    32'(sz >= af_t));
        check({p, ".aempty"}, k ? 32'(ae_b)    : 32'(ae_a),    32'(sz <= 1));
        check({p, ".ovf"},    k ? 32'(ovf_b)   : 32'(ovf_a),   32'(exp_ovf[k]));
        check({p, ".unf"},    k ? 32'(unf_b)   : 32'(unf_a),   32'(exp_unf[k]));
        check({p, ".data"},   k ? 32'(dout_b)  : 32'(dout_a),  32'(ed));
    endtask

    // One clock of FIFO behaviour from the rules: flush empties, a push is
    // taken unless full, a pop is taken unless empty, rejections pulse.
    task automatic model_step(input int k);
        int         sz;
        int         cap;
        logic [7:0] v;
        sz  = k ? mq1.size() : mq0.size();
        cap = k ? 4 : 3;
        exp_ovf[k] = 1'b0;
        exp_unf[k] = 1'b0;
        if (flush) begin
            if (k == 1) mq1.delete();
            else        mq0.delete();
        end else begin
            exp_ovf[k] = push && (sz == cap);
            exp_unf[k] = pop  && (sz == 0);
            if (pop && sz != 0) begin
                if (k == 1) begin
                    v          = mq1.pop_front();
                    exp_dout_b = v;
                end else begin
                    v = mq0.pop_front();
                end
            end
            if (push && sz != cap) begin
                if (k == 1) mq1.push_back(din);
                else        mq0.push_back(din);
            end
        end
    endtask

    task automatic drive(input logic pu, input logic po, input logic fl, input logic [7:0] d);
        push  = pu;
        pop   = po;
        flush = fl;
        din   = d;
    endtask

    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_all(0);
        check_all(1);
    endtask

    // Called 1 time unit after an edge: reset is asserted and checked well
    // before the next edge, then released, also away from any edge.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        mq0.delete();
        mq1.delete();
        exp_dout_b = 8'h00;
        exp_ovf    = '0;
        exp_unf    = '0;
        check_all(0);
        check_all(1);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int pp;
        rst_n      = 1'b0;
        exp_dout_b = 8'h00;
        exp_ovf    = '0;
        exp_unf    = '0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset values
        #12;
        check_all(0);
        check_all(1);

        // Release away from an edge; first push lands on the very next edge.
        @(negedge clk);
        rst_n = 1'b1;

        // Fill: a (3 deep) becomes full and rejects 0xD, b (4 deep) takes it.
        drive(1'b1, 1'b0, 1'b0, 8'h0A); cycle();
        drive(1'b1, 1'b0, 1'b0, 8'h0B); cycle();
        drive(1'b1, 1'b0, 1'b0, 8'h0C); cycle();
        drive(1'b1, 1'b0, 1'b0, 8'h0D); cycle();
        drive(1'b0, 1'b0, 1'b0, 8'h00); cycle();

        // Push+pop while full: pop taken, push rejected with overflow.
        drive(1'b1, 1'b1, 1'b0, 8'h0E); cycle();

        // Drain: a underflows on the last pop, b returns B, C, D.
        drive(1'b0, 1'b1, 1'b0, 8'h00); cycle();
        drive(1'b0, 1'b1, 1'b0, 8'h00); cycle();
        drive(1'b0, 1'b1, 1'b0, 8'h00); cycle();
        drive(1'b0, 1'b0, 1'b0, 8'h00); cycle();

        // Push+pop while empty: underflow, push still accepted.
        drive(1'b1, 1'b1, 1'b0, 8'h55); cycle();
        drive(1'b0, 1'b0, 1'b0, 8'h00); cycle();

        // One-entry-deep stream of 0..9 through wrapping pointers.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(i)); cycle();
        end

        // Two entries, then flush with a simultaneous push.
        drive(1'b1, 1'b0, 1'b0, 8'h77); cycle();
        drive(1'b1, 1'b0, 1'b1, 8'h88); cycle();
        drive(1'b0, 1'b1, 1'b1, 8'h00); cycle();
        drive(1'b0, 1'b0, 1'b0, 8'h00); cycle();

        // Burst interrupted by an asynchronous reset.
        drive(1'b1, 1'b0, 1'b0, 8'h11); cycle();
        drive(1'b1, 1'b0, 1'b0, 8'h22); cycle();
        drive(1'b1, 1'b1, 1'b0, 8'h33);
        mid_reset();
        cycle();

        // Randomized traffic, alternating push-heavy and pop-heavy phases.
        for (int i = 0; i < 400; i++) begin
            pp = ((i / 40) % 2 == 0) ? 75 : 30;
            drive($urandom_range(0, 99) < pp,
                  $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 3,
                  8'($urandom));
            cycle();
            if (i == 250) mid_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
